// File: rtl/sample_pacer.sv
// sample_pacer: buffers signed 14-bit synth samples in a small FIFO and
// releases one every CYCLES_PER_SAMPLE clocks as an attenuated,
// offset-binary DAC code; counts ticks that find the FIFO empty.
module sample_pacer #(
    parameter int DEPTH             = 8,
    parameter int CYCLES_PER_SAMPLE = 1024,
    parameter int CODE_WIDTH        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [13:0]    sample,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [2:0]            volume,
    input  logic                  mute,
    output logic [CODE_WIDTH-1:0] dac_code,
    output logic                  dac_next,
    output logic [15:0]           underflow_count
);

    localparam int PC_W  = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PC_W-1:0]       PC_LAST  = PC_W'(CYCLES_PER_SAMPLE - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CODE_WIDTH-1:0] MIDSCALE = CODE_WIDTH'(1) << (CODE_WIDTH - 1);

    logic [PC_W-1:0]     pc;
    logic                tick;
    logic [13:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                do_push;
    logic                do_pop;
    logic signed [13:0]  shifted;
    logic [13:0]         offset;
    logic [CODE_WIDTH-1:0] code_next;

    // Handshake, pacing tick and conversion of the FIFO head.
    always_comb begin
        sample_ready = !rst && (count < CNT_FULL);
        tick         = (pc == PC_LAST);
        do_push      = sample_valid && sample_ready;
        do_pop       = tick && (count != '0);
        shifted      = $signed(mem[rd_ptr]) >>> volume;
        offset       = {~shifted[13], shifted[12:0]};
        code_next    = mute ? MIDSCALE : CODE_WIDTH'(offset >> (14 - CODE_WIDTH));
    end

    // Pace counter: 0..CYCLES_PER_SAMPLE-1, wrapping on tick.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PC_W'(1);
        end
    end

    // FIFO storage; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= sample;
        end
    end

    // FIFO pointers and occupancy; full/empty come from count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // DAC code update on pop, one-cycle strobe, saturating underflow count.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code        <= MIDSCALE;
            dac_next        <= 1'b0;
            underflow_count <= '0;
        end else begin
            dac_next <= do_pop;
            if (do_pop) begin
                dac_code <= code_next;
            end
            if (tick && (count == '0) && (underflow_count != '1)) begin
                underflow_count <= underflow_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Scoreboard bench for sample_pacer: a queue-based reference model predicts
// each popped code; a monitor compares whenever dac_next is presented.
module tb_sample_pacer;

    localparam int DEPTH = 4;
    localparam int CPS   = 16;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [13:0]   sample = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [2:0]    volume = '0;
    logic          mute = 1'b0;
    logic [CW-1:0] dac_code;
    logic          dac_next;
    logic [15:0]   underflow_count;

    always #5 clk = ~clk;

    sample_pacer #(
        .DEPTH(DEPTH),
        .CYCLES_PER_SAMPLE(CPS),
        .CODE_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample(sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .volume(volume),
        .mute(mute),
        .dac_code(dac_code),
        .dac_next(dac_next),
        .underflow_count(underflow_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int      mq[$];          // samples held in the modelled FIFO
    int      expq[$];        // scoreboard: predicted codes awaiting dac_next
    int      m_pc = 0;
    int      m_ucnt = 0;
    int      m_code = 512;
    bit      m_next = 1'b0;
    int      m_s;
    bit      m_push;
    longint  cycle = 0;
    int      log_code[$];
    longint  log_cyc[$];
    longint  acc_cyc;

    // Floor-divide by 2^vol, offset by half range, keep the top CW of 14 bits.
    function automatic int ref_code(input int s, input int vol, input bit mu);
        int p;
        int a;
        if (mu) return 512;
        p = 1 << vol;
        if (s >= 0) a = s / p;
        else        a = -((-s + p - 1) / p);
        return (a + 8192) / 16;
    endfunction

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            mq.delete();
            expq.delete();
            m_pc   = 0;
            m_ucnt = 0;
            m_code = 512;
            m_next = 1'b0;
        end else begin
            m_push = sample_valid && (mq.size() < DEPTH);
            m_next = 1'b0;
            if (m_pc == CPS - 1) begin
                if (mq.size() > 0) begin
                    m_s    = mq.pop_front();
                    m_code = ref_code(m_s, int'(volume), mute);
                    expq.push_back(m_code);
                    m_next = 1'b1;
                end else if (m_ucnt < 65535) begin
                    m_ucnt++;
                end
            end
            if (m_push) mq.push_back(int'($signed(sample)));
            m_pc = (m_pc + 1) % CPS;
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        chk("dac_next", int'(dac_next), int'(m_next));
        chk("sample_ready", int'(sample_ready), int'(!rst && (mq.size() < DEPTH)));
        chk("underflow_count", int'(underflow_count), m_ucnt);
        chk("dac_code_held", int'(dac_code), m_code);
        if (dac_next) begin
            if (expq.size() == 0) begin
                chk("unexpected_pop", int'(dac_code), -1);
            end else begin
                chk("pop_code", int'(dac_code), expq.pop_front());
            end
            log_code.push_back(int'(dac_code));
            log_cyc.push_back(cycle);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [13:0] s);
        bit done;
        done = 1'b0;
        sample = s;
        sample_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (sample_ready) begin
                acc_cyc = cycle + 1;
                done = 1'b1;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 300 && log_code.size() < n; i++) @(negedge clk);
        if (log_code.size() < n) chk("wait_pops_timeout", log_code.size(), n);
    endtask

    task automatic align_pc0();
        for (int i = 0; i < 200 && !(m_pc == 0 && mq.size() == 0); i++) @(negedge clk);
        if (!(m_pc == 0 && mq.size() == 0)) chk("align_timeout", m_pc, 0);
    endtask

    function automatic int logged(input int k);
        if (k < log_code.size()) return log_code[k];
        return -1;
    endfunction

    function automatic int gap(input int k);
        if (k + 1 < log_cyc.size()) return int'(log_cyc[k+1] - log_cyc[k]);
        return -1;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        int dens;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_dac_code", int'(dac_code), 512);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_dac_next", int'(dac_next), 0);

        // Idle: three empty ticks.
        repeat (48) @(negedge clk);
        chk("idle_underflow", int'(underflow_count), 3);
        chk("idle_dac_code", int'(dac_code), 512);

        // Full-scale conversion at volume 0.
        log_code.delete(); log_cyc.delete();
        push(14'h1FFF); push(14'h2000); push(14'h0000);
        wait_pops(3);
        chk("fs_code0", logged(0), 1023);
        chk("fs_code1", logged(1), 0);
        chk("fs_code2", logged(2), 512);
        chk("fs_gap0", gap(0), 16);
        chk("fs_gap1", gap(1), 16);

        // Attenuation.
        log_code.delete(); log_cyc.delete();
        volume = 3'd1;
        push(14'h3000);
        wait_pops(1);
        chk("atten_code", logged(0), 384);
        volume = 3'd0;

        // Backpressure with five back-to-back samples.
        align_pc0();
        log_code.delete(); log_cyc.delete();
        push(14'h0100); push(14'h0200); push(14'h0300); push(14'h0400);
        chk("bp_not_ready", int'(sample_ready), 0);
        push(14'h0500);
        chk("bp_5th_after_pop", (log_cyc.size() > 0) ? int'(acc_cyc - log_cyc[0]) : -1, 1);
        wait_pops(5);
        chk("bp_code0", logged(0), 528);
        chk("bp_code1", logged(1), 544);
        chk("bp_code2", logged(2), 560);
        chk("bp_code3", logged(3), 576);
        chk("bp_code4", logged(4), 592);

        // Mute.
        log_code.delete(); log_cyc.delete();
        mute = 1'b1;
        push(14'h1FFF);
        wait_pops(1);
        chk("mute_code", logged(0), 512);
        mute = 1'b0;
        #1;
        chk("mute_drained_ready", int'(sample_ready), 1);

        // Reset mid-stream with three samples queued.
        align_pc0();
        log_code.delete(); log_cyc.delete();
        push(14'h1FFF); push(14'h0100); push(14'h0200); push(14'h0300);
        wait_pops(1);
        chk("pre_rst_code", logged(0), 1023);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_code", int'(dac_code), 512);
        chk("mid_rst_underflow", int'(underflow_count), 0);
        chk("mid_rst_ready", int'(sample_ready), 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("mid_rst_no_next", int'(dac_next), 0);
        end

        // Randomized traffic with varying density, volume, mute and resets.
        dens = 4;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i % 200 == 0) dens = int'($urandom_range(0, 15));
            sample_valid = ($urandom_range(0, 15) < dens);
            sample       = 14'($urandom);
            volume       = 3'($urandom_range(0, 7));
            mute         = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        mute = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sample_pacer.md
# sample_pacer

Downstream consumer of the synthesizer's sample stream. Accepts signed 14-bit samples over a ready/valid handshake, buffers them in a small FIFO, and releases one sample every `CYCLES_PER_SAMPLE` clocks to the PWM DAC as an attenuated, offset-binary code. It decouples the synth's bursty, state-machine-paced production from the fixed audio sample rate and reports underruns.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `CYCLES_PER_SAMPLE`, 1024 — clocks per output sample; ≥2.
- `CODE_WIDTH`, 10 — DAC code width; 1..14.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sample`  in  14  signed two's-complement input sample.
- `sample_valid`  in  1  `sample` is valid.
- `sample_ready`  out  1  FIFO can accept; transfer on `sample_valid && sample_ready`.
- `volume`  in  3  attenuation; arithmetic right shift by 0..7.
- `mute`  in  1  force midscale output; the FIFO still drains.
- `dac_code`  out  CODE_WIDTH  unsigned code to the DAC.
- `dac_next`  out  1  one-cycle pulse; `dac_code` was just updated from a popped sample.
- `underflow_count`  out  16  saturating count of empty-FIFO ticks.

## Operation
- Pace counter `pc` counts 0..`CYCLES_PER_SAMPLE`-1 and wraps to 0.
- `tick` = (`pc` == `CYCLES_PER_SAMPLE`-1).
- FIFO:
  - Circular buffer with registered occupancy count 0..`DEPTH`.
  - `sample_ready` = !rst && (count < `DEPTH`), derived from the registered count only.
  - Push when `sample_valid && sample_ready`.
  - Pop on `tick` when count > 0.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - No bypass: a sample pushed in a cycle where count == 0 is not popped in that cycle.
- Conversion on pop, using the `volume` and `mute` values at the pop cycle:
  - a = sample >>> volume (14-bit arithmetic shift).
  - u = a with bit 13 inverted (equivalent to a + 8192, unsigned 14-bit).
  - `dac_code` = u[13 : 14-CODE_WIDTH].
  - If `mute`: `dac_code` = 2^(CODE_WIDTH-1); the popped sample is discarded.
- Underflow, on `tick` with count == 0:
  - No pop; `dac_code` holds its value; `dac_next` stays 0.
  - `underflow_count` increments and saturates at 65535.
- Pointer wrap: pointers are log2(`DEPTH`) bits and wrap naturally; full and empty are distinguished by count, not by pointers.

## Timing
- Reset values (rst high at an edge):
  - `pc`=0, FIFO empty (count 0, pointers 0).
  - `dac_code`=2^(CODE_WIDTH-1), `dac_next`=0, `underflow_count`=0.
  - `sample_ready`=0 while rst is high, and 1 in the first cycle after release.
- First `tick` occurs in the cycle where `pc`=`CYCLES_PER_SAMPLE`-1, which is the `CYCLES_PER_SAMPLE`-th cycle after reset release.
- Pop latency: `dac_code` and `dac_next` update at the clock edge that ends the `tick` cycle. `dac_next` is high for exactly that following cycle.
- A sample pushed at edge E is poppable on any `tick` cycle strictly after E.
- `sample_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- Reset mid-operation discards all queued samples and restarts pacing from `pc`=0.

## Test plan
Bench parameters: `DEPTH`=4, `CYCLES_PER_SAMPLE`=16, `CODE_WIDTH`=10.
- Reset, idle:
  - After release: `dac_code`=512, `sample_ready`=1, `dac_next`=0.
  - With no input for 3 ticks: `underflow_count`=3, `dac_code` stays 512, `dac_next` never pulses.
- Full-scale conversion, `volume`=0:
  - Push 0x1FFF, 0x2000, 0x0000.
  - Successive ticks produce `dac_code` = 1023, 0, 512, each with a single-cycle `dac_next`, 16 cycles apart.
- Attenuation: push 0x3000 (−4096) with `volume`=1 at pop → `dac_code`=384.
- Backpressure:
  - Hold `sample_valid` high with 5 distinct samples starting at `pc`=0.
  - 4 are accepted on consecutive cycles, then `sample_ready`=0.
  - The 5th is accepted the cycle after the first pop.
  - Output order matches input order.
- Mute: `mute`=1, push 0x1FFF → `dac_code`=512, `dac_next` pulses, FIFO count returns to 0.
- Reset mid-stream:
  - With 3 samples queued, assert rst for 1 cycle.
  - Result: `dac_code`=512, FIFO empty, no `dac_next` for the next 15 cycles, `underflow_count`=0.
